// File: rtl/eei_pkg.sv
// Execution-environment definitions shared across the core: widths, memory map
// and the ACLINT register offsets.
package eei;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] Addr;
    typedef logic [63:0]     UInt64;

    localparam Addr MMAP_ACLINT_BEGIN = 64'h0000_0000_0200_0000;

    localparam int unsigned ACLINT_OFFS_W = 16;

    localparam logic [ACLINT_OFFS_W-1:0] ACLINT_MSIP0_OFFSET     = 16'h0000;
    localparam logic [ACLINT_OFFS_W-1:0] ACLINT_MTIMECMP0_OFFSET = 16'h4000;
    localparam logic [ACLINT_OFFS_W-1:0] ACLINT_MTIME_OFFSET     = 16'hBFF8;

    typedef enum logic [1:0] {
        ACLINT_SEL_NONE,
        ACLINT_SEL_MSIP0,
        ACLINT_SEL_MTIMECMP0,
        ACLINT_SEL_MTIME
    } aclint_sel_e;

endpackage

// File: rtl/aclint_if.sv
// Timer/software-interrupt side channel from the ACLINT to the CSR unit.
interface aclint_if;
    logic       msip;
    logic       mtip;
    eei::UInt64 mtime;

    modport master (output msip, output mtip, output mtime);
    modport slave  (input  msip, input  mtip, input  mtime);
endinterface

// File: rtl/aclint_memory.sv
// Memory-mapped ACLINT: MSIP0, MTIMECMP0 and a prescaled 64-bit MTIME, with a
// single-cycle response bus and registered interrupt outputs.
module aclint_memory
    import eei::*;
#(
    parameter Addr         BASE_ADDR = MMAP_ACLINT_BEGIN,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       membus_valid,
    output logic       membus_ready,
    input  Addr        membus_addr,
    input  logic       membus_wen,
    input  UInt64      membus_wdata,
    input  logic [7:0] membus_wmask,
    output logic       membus_rvalid,
    output UInt64      membus_rdata,
    aclint_if.master   aclint
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic UInt64 merge_bytes(input UInt64 old_v, input UInt64 new_v,
                                          input logic [7:0] mask);
        UInt64 res;
        res = old_v;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [PRESC_W-1:0] presc_q, presc_d;
    UInt64              mtime_q, mtime_d;
    UInt64              mtimecmp_q, mtimecmp_d;
    logic               msip_q, msip_d;
    logic               mtip_q, mtip_d;
    logic               rvalid_q, rvalid_d;
    UInt64              rdata_q, rdata_d;

    Addr         offset;
    aclint_sel_e sel;
    logic        accept;
    logic        tick;
    logic        unused_offs_lo;

    assign membus_ready   = rst;
    assign accept         = membus_valid && membus_ready;
    assign offset         = membus_addr - BASE_ADDR;
    assign unused_offs_lo = ^offset[2:0];
    assign tick           = (presc_q == PRESC_W'(TICK_DIV - 1));

    // Doubleword decode; anything outside the 64 KiB window is unmapped.
    always_comb begin
        sel = ACLINT_SEL_NONE;
        if (offset[XLEN-1:ACLINT_OFFS_W] == '0) begin
            if (offset[15:3] == ACLINT_MSIP0_OFFSET[15:3]) begin
                sel = ACLINT_SEL_MSIP0;
            end else if (offset[15:3] == ACLINT_MTIMECMP0_OFFSET[15:3]) begin
                sel = ACLINT_SEL_MTIMECMP0;
            end else if (offset[15:3] == ACLINT_MTIME_OFFSET[15:3]) begin
                sel = ACLINT_SEL_MTIME;
            end
        end
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rvalid_d   = accept;
        rdata_d    = '0;

        if (accept && membus_wen) begin
            unique case (sel)
                ACLINT_SEL_MSIP0: begin
                    if (membus_wmask[0]) msip_d = membus_wdata[0];
                end
                ACLINT_SEL_MTIMECMP0: begin
                    mtimecmp_d = merge_bytes(mtimecmp_q, membus_wdata, membus_wmask);
                end
                // Bus write beats the tick; untouched bytes keep the pre-increment value.
                ACLINT_SEL_MTIME: begin
                    mtime_d = merge_bytes(mtime_q, membus_wdata, membus_wmask);
                    presc_d = '0;
                end
                default: ;
            endcase
        end else if (accept) begin
            unique case (sel)
                ACLINT_SEL_MSIP0:     rdata_d = UInt64'(msip_q);
                ACLINT_SEL_MTIMECMP0: rdata_d = mtimecmp_q;
                ACLINT_SEL_MTIME:     rdata_d = mtime_q;
                default:              rdata_d = '0;
            endcase
        end

        mtip_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign membus_rvalid = rvalid_q;
    assign membus_rdata  = rdata_q;
    assign aclint.msip   = msip_q;
    assign aclint.mtip   = mtip_q;
    assign aclint.mtime  = mtime_q;

endmodule

// File: tb/tb_aclint_memory.sv
// Scoreboard bench for aclint_memory: bus responses checked by a monitor,
// timer/interrupt outputs checked against hand-computed values.
module tb_aclint_memory;
    import eei::*;

    localparam Addr BASE = 64'h0000_0000_0200_0000;
    localparam logic [15:0] OFF_MSIP  = 16'h0000;
    localparam logic [15:0] OFF_CMP   = 16'h4000;
    localparam logic [15:0] OFF_MTIME = 16'hBFF8;
    localparam logic [15:0] OFF_UNMAP = 16'h8000;

    logic       clk = 1'b0;
    logic       rst, valid, ready, wen, rvalid;
    Addr        addr;
    UInt64      wdata, rdata;
    logic [7:0] wmask;

    logic       rst4, valid4, ready4, wen4, rvalid4;
    Addr        addr4;
    UInt64      wdata4, rdata4;
    logic [7:0] wmask4;

    aclint_if acl ();
    aclint_if acl4 ();

    UInt64 exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    aclint_memory #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .membus_valid(valid), .membus_ready(ready),
        .membus_addr(addr), .membus_wen(wen), .membus_wdata(wdata),
        .membus_wmask(wmask), .membus_rvalid(rvalid), .membus_rdata(rdata),
        .aclint(acl)
    );

    aclint_memory #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst4), .membus_valid(valid4), .membus_ready(ready4),
        .membus_addr(addr4), .membus_wen(wen4), .membus_wdata(wdata4),
        .membus_wmask(wmask4), .membus_rvalid(rvalid4), .membus_rdata(rdata4),
        .aclint(acl4)
    );

    task automatic chk(input string name, input UInt64 act, input UInt64 exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bus request, accepted on the next edge; the expected response is queued.
    task automatic bus(input logic w, input logic [15:0] off, input UInt64 d,
                       input logic [7:0] m, input UInt64 exp);
        valid = 1'b1;
        wen   = w;
        addr  = BASE + Addr'(off);
        wdata = d;
        wmask = m;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        valid = 1'b0;
        wen   = 1'b0;
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; wen = 1'b0; addr = '0; wdata = '0; wmask = '0;
        rst4 = 1'b0; valid4 = 1'b0; wen4 = 1'b0; addr4 = '0; wdata4 = '0; wmask4 = '0;

        fork
            forever begin
                @(negedge clk);
                if (rvalid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_rvalid", UInt64'(rvalid), 64'd0);
                    end else begin
                        chk("rdata", rdata, exp_q.pop_front());
                    end
                end
            end
        join_none

        cyc(3);
        chk("rst_mtime", acl.mtime, 64'd0);
        chk("rst_msip", UInt64'(acl.msip), 64'd0);
        chk("rst_mtip", UInt64'(acl.mtip), 64'd0);
        chk("rst_ready", UInt64'(ready), 64'd0);
        chk("rst_rvalid", UInt64'(rvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst4_mtime", acl4.mtime, 64'd0);

        rst = 1'b1;
        #1;
        chk("ready_after_rst", UInt64'(ready), 64'd1);

        cyc(10);
        chk("mtime_10", acl.mtime, 64'd10);
        bus(1'b0, OFF_MTIME, '0, 8'h00, 64'd10);
        chk("mtip_initial", UInt64'(acl.mtip), 64'd0);

        bus(1'b1, OFF_CMP, 64'd20, 8'hFF, 64'd0);
        chk("mtime_12", acl.mtime, 64'd12);
        cyc(7);
        chk("mtime_19", acl.mtime, 64'd19);
        chk("mtip_at_19", UInt64'(acl.mtip), 64'd0);
        cyc(1);
        chk("mtip_at_20", UInt64'(acl.mtip), 64'd1);
        bus(1'b1, OFF_CMP, 64'd100, 8'hFF, 64'd0);
        chk("mtip_fall", UInt64'(acl.mtip), 64'd0);
        bus(1'b0, OFF_CMP, '0, 8'h00, 64'd100);

        bus(1'b1, OFF_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0);
        bus(1'b1, OFF_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0);
        chk("mtime_fe", acl.mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mtip_fe", UInt64'(acl.mtip), 64'd0);
        bus(1'b0, OFF_MTIME, '0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mtip_ff", UInt64'(acl.mtip), 64'd1);
        bus(1'b0, OFF_MTIME, '0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mtime_wrap", acl.mtime, 64'd0);
        chk("mtip_wrap", UInt64'(acl.mtip), 64'd0);
        bus(1'b0, OFF_MTIME, '0, 8'h00, 64'd0);

        bus(1'b1, OFF_MTIME, 64'hAAAA_BBBB_0000_0000, 8'hFF, 64'd0);
        bus(1'b1, OFF_MTIME, 64'h0000_0000_1234_5678, 8'h0F, 64'd0);
        chk("mtime_partial", acl.mtime, 64'hAAAA_BBBB_1234_5678);
        cyc(1);
        chk("mtime_partial_inc", acl.mtime, 64'hAAAA_BBBB_1234_5679);

        bus(1'b1, OFF_CMP, 64'h0000_0000_0000_0055, 8'h01, 64'd0);
        bus(1'b0, OFF_CMP, '0, 8'h00, 64'hFFFF_FFFF_FFFF_FF55);

        bus(1'b1, OFF_MSIP, 64'h0000_0000_FFFF_FFFF, 8'hFF, 64'd0);
        chk("msip_set", UInt64'(acl.msip), 64'd1);
        bus(1'b0, OFF_MSIP, '0, 8'h00, 64'd1);
        bus(1'b1, OFF_MSIP, 64'd0, 8'hFE, 64'd0);
        chk("msip_masked", UInt64'(acl.msip), 64'd1);
        bus(1'b1, OFF_UNMAP, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'd0);
        bus(1'b0, OFF_UNMAP, '0, 8'h00, 64'd0);
        bus(1'b0, OFF_CMP, '0, 8'h00, 64'hFFFF_FFFF_FFFF_FF55);
        chk("msip_unmapped_wr", UInt64'(acl.msip), 64'd1);

        // Request raised together with reset must never be answered.
        valid = 1'b1; wen = 1'b0; addr = BASE + Addr'(OFF_MTIME);
        rst = 1'b0;
        #1;
        chk("ready_in_rst", UInt64'(ready), 64'd0);
        cyc(1);
        valid = 1'b0;
        chk("rst2_mtime", acl.mtime, 64'd0);
        chk("rst2_msip", UInt64'(acl.msip), 64'd0);
        chk("rst2_rvalid", UInt64'(rvalid), 64'd0);
        chk("rst2_rdata", rdata, 64'd0);
        cyc(2);
        rst = 1'b1;
        #1;
        bus(1'b0, OFF_CMP, '0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);

        rst4 = 1'b1;
        cyc(3);
        chk("div4_mtime_0", acl4.mtime, 64'd0);
        cyc(1);
        chk("div4_mtime_1", acl4.mtime, 64'd1);
        cyc(4);
        chk("div4_mtime_2", acl4.mtime, 64'd2);
        cyc(2);
        rst4 = 1'b0;
        cyc(1);
        chk("div4_rst_mtime", acl4.mtime, 64'd0);
        chk("div4_rst_mtip", UInt64'(acl4.mtip), 64'd0);
        chk("div4_rst_msip", UInt64'(acl4.msip), 64'd0);
        chk("div4_rst_ready", UInt64'(ready4), 64'd0);
        chk("div4_rst_rvalid", UInt64'(rvalid4), 64'd0);
        chk("div4_rst_rdata", rdata4, 64'd0);
        rst4 = 1'b1;
        cyc(3);
        chk("div4_presc_rst", acl4.mtime, 64'd0);
        cyc(1);
        chk("div4_after_rst", acl4.mtime, 64'd1);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) cyc(1);
        if (exp_q.size() != 0) begin
            chk("missing_rvalid", UInt64'(exp_q.size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aclint_memory.md
ACLINT_MEMORY -- requirements
Module: aclint_memory

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 'h0200_0000, byte base of the ACLINT window.
REQ-002 SHALL have parameter TICK_DIV, default 1, clk cycles per mtime increment (>=1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port membus_valid  input  1  request valid.
REQ-006 SHALL have port membus_ready  output  1  request accept.
REQ-007 SHALL have port membus_addr  input  Addr  byte address of the request.
REQ-008 SHALL have port membus_wen  input  1  1 = write, 0 = read.
REQ-009 SHALL have port membus_wdata  input  64  write data, 8-byte aligned lanes.
REQ-010 SHALL have port membus_wmask  input  8  byte enables for writes.
REQ-011 SHALL have port membus_rvalid  output  1  response valid, reads and writes.
REQ-012 SHALL have port membus_rdata  output  64  read data.
REQ-013 SHALL have port aclint  aclint_if.master  --  drives msip, mtip and mtime (64) to csrunit.

Function
REQ-014 SHALL decode offset = membus_addr - BASE_ADDR, using bits [15:3] for the doubleword: 'h0000 MSIP0, 'h4000 MTIMECMP0, 'hBFF8 MTIME; every other offset is unmapped.
REQ-015 SHALL drive membus_ready = 1 whenever rst is high; a request is accepted when valid && ready.
REQ-016 SHALL assert membus_rvalid exactly one cycle after every accepted request, for one cycle, with no back-pressure.
REQ-017 SHALL return in membus_rdata the register value sampled in the accept cycle, before that cycle's update; writes return 0; unmapped reads return 0.
REQ-018 SHALL apply writes byte-wise: a byte is updated only where wmask[i]=1; unmapped writes are ignored.
REQ-019 SHALL implement MSIP0 as a 1-bit register (bit 0 writable); the other bits read 0; aclint.msip = MSIP0.
REQ-020 SHALL implement a prescaler counting 0..TICK_DIV-1; mtime increments by 1 in the cycle the prescaler wraps. With TICK_DIV=1, mtime increments every cycle.
REQ-021 SHALL wrap mtime modulo 2^64 ('hFFFF_FFFF_FFFF_FFFF -> 0).
REQ-022 SHALL let a bus write to MTIME take priority over a same-cycle increment; unwritten bytes take the pre-increment value; the prescaler resets to 0 on any MTIME write.
REQ-023 SHALL register aclint.mtip = (mtime >= mtimecmp), unsigned 64-bit, evaluated on the next-state values so that mtip is valid in the same cycle as the new mtime.
REQ-024 SHALL drive aclint.mtime directly from the mtime register.

Reset
REQ-025 SHALL, while rst=0 at a clk edge, set mtime=0, prescaler=0, mtimecmp='hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, membus_rvalid=0, membus_rdata=0.
REQ-026 SHALL hold membus_ready=0 during reset; a request in flight is dropped and produces no rvalid after reset.

Structure
REQ-027 SHALL take XLEN, Addr and UInt64 from eei; ACLINT offsets (MSIP0, MTIMECMP0, MTIME) and MMAP_ACLINT_BEGIN SHALL be added to eei.
REQ-028 SHALL place the aclint_if definition (msip, mtip, mtime; master/slave modports) in the shared interface file.
REQ-029 SHALL be a single module with no sub-module; byte-mask merge SHALL be a local function.

Verification
REQ-030 After reset with TICK_DIV=1, hold 10 cycles, then read MTIME -> rvalid next cycle, rdata = 10 (the accept-cycle value); mtip=0.
REQ-031 Write MTIMECMP0=20 with wmask 'hFF -> mtip rises in the cycle mtime becomes 20; then write MTIMECMP0=100 -> mtip falls the next cycle.
REQ-032 Write MTIME='hFFFF_FFFF_FFFF_FFFE -> reads 'hFFFF_FFFF_FFFF_FFFF, then 0, on successive cycles (wrap-around); mtip=0 with mtimecmp=all-ones... until compare.
REQ-033 Write MTIME with wmask 'h0F, data 'h0000_0000_1234_5678, while an increment is due -> low 4 bytes = 'h1234_5678, high bytes unchanged, no increment that cycle.
REQ-034 Write MSIP0 = 'hFFFF_FFFF -> aclint.msip=1, read back = 1; write to unmapped offset 'h8000 -> no state change, rvalid still pulses; read 'h8000 -> 0.
REQ-035 With TICK_DIV=4, mtime increments once every 4 cycles; drive rst=0 mid-count -> all outputs take REQ-025 values at the next edge.
